// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// The round-robin tie-break is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  // One-hot owner encodings, also used as the out_grant value
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  localparam int DEFAULT_CACHE_LINE_SIZE = 128;
  localparam int DEFAULT_ADDR_WIDTH      = 32;

endpackage

// File: rtl/arb_picker.sv
// Combinational tie-break between the icache and dcache requests.
// With MEM_ARB_ROUND_ROBIN_EN defined, a tie goes to whoever was not the
// last owner; otherwise the dcache wins every tie.
module arb_picker
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  logic [1:0] last_owner,
  output logic [1:0] winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
`else
  // Fixed priority has no use for the previous owner
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner;
`endif

  // Pick a one-hot winner; single requesters always win outright
  always_comb begin
    winner = GRANT_NONE;
    if (req_i && req_d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = (last_owner == GRANT_D) ? GRANT_I : GRANT_D;
`else
      winner = GRANT_D;
`endif
    end else if (req_i) begin
      winner = GRANT_I;
    end else if (req_d) begin
      winner = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide main-memory port between the icache and dcache.
// A registered FSM grants one owner and holds it until memory completes
// or the owner drops its request. Define MEM_ARB_ROUND_ROBIN_EN for a
// round-robin tie-break; by default the dcache wins ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = DEFAULT_CACHE_LINE_SIZE,
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_i_read_en,
  input  logic                       in_i_write_en,
  input  logic [ADDR_WIDTH-1:0]      in_i_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_i_write_data,
  output logic                       out_i_ready,
  output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
  input  logic                       in_d_read_en,
  input  logic                       in_d_write_en,
  input  logic [ADDR_WIDTH-1:0]      in_d_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
  output logic                       out_d_ready,
  output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [ADDR_WIDTH-1:0]      out_mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
  input  logic                       in_mem_ready,
  output logic [1:0]                 out_grant
);

  arb_state_t state_reg;
  arb_state_t state_next;
  logic       req_i;
  logic       req_d;
  logic [1:0] winner;
  logic [1:0] last_owner;

  assign req_i = in_i_read_en | in_i_write_en;
  assign req_d = in_d_read_en | in_d_write_en;

  // Read data goes to both caches; each qualifies it with its own ready
  assign out_i_read_data = in_mem_read_data;
  assign out_d_read_data = in_mem_read_data;

  arb_picker u_picker (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_owner (last_owner),
    .winner     (winner)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [1:0] last_owner_reg;

  // Remember who was granted last so the next tie goes the other way
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_reg <= GRANT_I;
    end else if (state_reg == IDLE && winner != GRANT_NONE) begin
      last_owner_reg <= winner;
    end
  end

  assign last_owner = last_owner_reg;
`else
  assign last_owner = GRANT_I;
`endif

  // State register; reset drops any in-flight transaction at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: grant from IDLE, release on completion or on abort
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (winner == GRANT_I) begin
          state_next = OWN_I;
        end else if (winner == GRANT_D) begin
          state_next = OWN_D;
        end
      end
      OWN_I: begin
        if (in_mem_ready || !req_i) begin
          state_next = IDLE;
        end
      end
      OWN_D: begin
        if (in_mem_ready || !req_d) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: forward the owner's request, return ready only to the owner
  always_comb begin
    out_grant          = GRANT_NONE;
    out_mem_read_en    = 1'b0;
    out_mem_write_en   = 1'b0;
    out_mem_addr       = '0;
    out_mem_write_data = '0;
    out_i_ready        = 1'b0;
    out_d_ready        = 1'b0;
    case (state_reg)
      OWN_I: begin
        out_grant          = GRANT_I;
        out_mem_read_en    = in_i_read_en;
        out_mem_write_en   = in_i_write_en;
        // Address and data drop to 0 together with the enables on abort
        out_mem_addr       = req_i ? in_i_addr : '0;
        out_mem_write_data = req_i ? in_i_write_data : '0;
        out_i_ready        = in_mem_ready;
      end
      OWN_D: begin
        out_grant          = GRANT_D;
        out_mem_read_en    = in_d_read_en;
        out_mem_write_en   = in_d_write_en;
        out_mem_addr       = req_d ? in_d_addr : '0;
        out_mem_write_data = req_d ? in_d_write_data : '0;
        out_d_ready        = in_mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expectations are hand-derived from
// the arbiter's cycle behaviour. Works with or without MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  localparam int LW = 128;
  localparam int AW = 32;

  logic          clk;
  logic          reset;
  logic          in_i_read_en, in_i_write_en;
  logic [AW-1:0] in_i_addr;
  logic [LW-1:0] in_i_write_data;
  logic          out_i_ready;
  logic [LW-1:0] out_i_read_data;
  logic          in_d_read_en, in_d_write_en;
  logic [AW-1:0] in_d_addr;
  logic [LW-1:0] in_d_write_data;
  logic          out_d_ready;
  logic [LW-1:0] out_d_read_data;
  logic          out_mem_read_en, out_mem_write_en;
  logic [AW-1:0] out_mem_addr;
  logic [LW-1:0] out_mem_write_data;
  logic [LW-1:0] in_mem_read_data;
  logic          in_mem_ready;
  logic [1:0]    out_grant;

  int tests_run;
  int tests_failed;

  localparam logic [LW-1:0] DATA_A5  = {16{8'hA5}};
  localparam logic [LW-1:0] DATA_5A  = {16{8'h5A}};
  localparam logic [LW-1:0] DATA_RST = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic [1:0] SECOND_TIE_WINNER = 2'b01;
`else
  localparam logic [1:0] SECOND_TIE_WINNER = 2'b10;
`endif

  mem_port_arbiter #(
    .CACHE_LINE_SIZE (LW),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .in_i_read_en       (in_i_read_en),
    .in_i_write_en      (in_i_write_en),
    .in_i_addr          (in_i_addr),
    .in_i_write_data    (in_i_write_data),
    .out_i_ready        (out_i_ready),
    .out_i_read_data    (out_i_read_data),
    .in_d_read_en       (in_d_read_en),
    .in_d_write_en      (in_d_write_en),
    .in_d_addr          (in_d_addr),
    .in_d_write_data    (in_d_write_data),
    .out_d_ready        (out_d_ready),
    .out_d_read_data    (out_d_read_data),
    .out_mem_read_en    (out_mem_read_en),
    .out_mem_write_en   (out_mem_write_en),
    .out_mem_addr       (out_mem_addr),
    .out_mem_write_data (out_mem_write_data),
    .in_mem_read_data   (in_mem_read_data),
    .in_mem_ready       (in_mem_ready),
    .out_grant          (out_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    in_i_read_en  = 1'b0; in_i_write_en = 1'b0; in_i_addr = '0; in_i_write_data = '0;
    in_d_read_en  = 1'b0; in_d_write_en = 1'b0; in_d_addr = '0; in_d_write_data = '0;
    in_mem_ready  = 1'b0;
    in_mem_read_data = DATA_RST;

    // Reset state
    @(posedge clk);
    #2;
    check("rst_grant",  out_grant, 2'b00);
    check("rst_mem_rd", out_mem_read_en, 1'b0);
    check("rst_mem_wr", out_mem_write_en, 1'b0);
    check("rst_addr",   out_mem_addr, '0);
    check("rst_irdy",   out_i_ready, 1'b0);
    check("rst_drdy",   out_d_ready, 1'b0);
    check("rst_idata",  out_i_read_data, DATA_RST);
    check("rst_ddata",  out_d_read_data, DATA_RST);
    $display("[TB] reset state checked");
    next_cycle(); reset = 1'b0;

    // Icache-only fill: request at cycle 0, memory ready at cycle 4
    next_cycle(); in_i_read_en = 1'b1; in_i_addr = 32'h1000; #1;
    check("i0_grant", out_grant, 2'b00);
    check("i0_rd",    out_mem_read_en, 1'b0);
    next_cycle(); #1;
    check("i1_grant", out_grant, 2'b01);
    check("i1_addr",  out_mem_addr, 32'h1000);
    check("i1_rd",    out_mem_read_en, 1'b1);
    next_cycle(); next_cycle();
    next_cycle(); in_mem_ready = 1'b1; in_mem_read_data = DATA_A5; #1;
    check("i4_irdy",  out_i_ready, 1'b1);
    check("i4_data",  out_i_read_data, DATA_A5);
    check("i4_drdy",  out_d_ready, 1'b0);
    next_cycle(); in_mem_ready = 1'b0; in_i_read_en = 1'b0; #1;
    check("i5_grant", out_grant, 2'b00);
    check("i5_irdy",  out_i_ready, 1'b0);
    check("i5_addr",  out_mem_addr, '0);
    $display("[TB] icache-only fill at 0x1000");

    // Spurious memory ready while idle
    next_cycle(); in_mem_ready = 1'b1; #1;
    check("sp_irdy",  out_i_ready, 1'b0);
    check("sp_drdy",  out_d_ready, 1'b0);
    next_cycle(); in_mem_ready = 1'b0; #1;
    check("sp_grant", out_grant, 2'b00);
    $display("[TB] spurious ready in idle");

    // Simultaneous requests: dcache first (last owner is icache)
    next_cycle();
    in_i_read_en = 1'b1; in_i_addr = 32'h1000;
    in_d_read_en = 1'b1; in_d_addr = 32'h2000; #1;
    check("t0_grant", out_grant, 2'b00);
    next_cycle(); #1;
    check("t1_grant", out_grant, 2'b10);
    check("t1_addr",  out_mem_addr, 32'h2000);
    next_cycle(); in_mem_ready = 1'b1; in_mem_read_data = DATA_5A; #1;
    check("t2_drdy",  out_d_ready, 1'b1);
    check("t2_ddata", out_d_read_data, DATA_5A);
    check("t2_irdy",  out_i_ready, 1'b0);
    next_cycle(); in_mem_ready = 1'b0; in_d_read_en = 1'b0; #1;
    check("t3_grant", out_grant, 2'b00);
    check("t3_rd",    out_mem_read_en, 1'b0);
    next_cycle(); #1;
    check("t4_grant", out_grant, 2'b01);
    check("t4_addr",  out_mem_addr, 32'h1000);
    next_cycle(); in_mem_ready = 1'b1; #1;
    check("t5_irdy",  out_i_ready, 1'b1);
    next_cycle(); in_mem_ready = 1'b0; in_i_read_en = 1'b0; #1;
    check("t6_grant", out_grant, 2'b00);
    $display("[TB] simultaneous requests 0x1000/0x2000");

    // Dcache write while icache requests
    next_cycle();
    in_i_read_en = 1'b1; in_i_addr = 32'h1000;
    in_d_write_en = 1'b1; in_d_addr = 32'h3000; in_d_write_data = 128'h1234; #1;
    check("w0_grant", out_grant, 2'b00);
    next_cycle(); #1;
    check("w1_grant", out_grant, 2'b10);
    check("w1_wr",    out_mem_write_en, 1'b1);
    check("w1_rd",    out_mem_read_en, 1'b0);
    check("w1_addr",  out_mem_addr, 32'h3000);
    check("w1_wdata", out_mem_write_data, 128'h1234);
    check("w1_irdy",  out_i_ready, 1'b0);
    next_cycle(); in_mem_ready = 1'b1; #1;
    check("w2_drdy",  out_d_ready, 1'b1);
    check("w2_irdy",  out_i_ready, 1'b0);
    next_cycle(); in_mem_ready = 1'b0; in_d_write_en = 1'b0; in_d_write_data = '0; #1;
    check("w3_grant", out_grant, 2'b00);
    check("w3_wr",    out_mem_write_en, 1'b0);
    $display("[TB] dcache write at 0x3000");

    // Icache is granted next; it aborts while dcache waits
    next_cycle(); in_d_read_en = 1'b1; in_d_addr = 32'h2000; #1;
    check("a0_grant", out_grant, 2'b01);
    check("a0_addr",  out_mem_addr, 32'h1000);
    check("a0_drdy",  out_d_ready, 1'b0);
    next_cycle(); in_i_read_en = 1'b0; #1;
    check("a1_rd",    out_mem_read_en, 1'b0);
    check("a1_addr",  out_mem_addr, '0);
    check("a1_grant", out_grant, 2'b01);
    next_cycle(); #1;
    check("a2_grant", out_grant, 2'b00);
    next_cycle(); #1;
    check("a3_grant", out_grant, 2'b10);
    check("a3_addr",  out_mem_addr, 32'h2000);
    check("a3_rd",    out_mem_read_en, 1'b1);
    $display("[TB] icache abort, dcache granted after");

    // Reset in the second cycle of the dcache transaction
    next_cycle(); reset = 1'b1; #1;
    check("r0_grant", out_grant, 2'b00);
    check("r0_rd",    out_mem_read_en, 1'b0);
    check("r0_addr",  out_mem_addr, '0);
    in_mem_ready = 1'b1; #1;
    check("r0_drdy",  out_d_ready, 1'b0);
    next_cycle(); reset = 1'b0; in_mem_ready = 1'b0; in_d_read_en = 1'b0; #1;
    check("r1_grant", out_grant, 2'b00);
    next_cycle(); in_mem_ready = 1'b1; #1;
    check("r2_drdy",  out_d_ready, 1'b0);
    check("r2_irdy",  out_i_ready, 1'b0);
    next_cycle(); in_mem_ready = 1'b0;
    $display("[TB] reset mid-transaction");

    // Back-to-back ties: requests held high through the idle bubble
    next_cycle();
    in_i_read_en = 1'b1; in_i_addr = 32'h1000;
    in_d_read_en = 1'b1; in_d_addr = 32'h2000; #1;
    check("b0_grant", out_grant, 2'b00);
    next_cycle(); #1;
    check("b1_grant", out_grant, 2'b10);
    next_cycle(); in_mem_ready = 1'b1; #1;
    check("b2_drdy",  out_d_ready, 1'b1);
    next_cycle(); in_mem_ready = 1'b0; #1;
    check("b3_grant", out_grant, 2'b00);
    next_cycle(); #1;
    check("b4_grant", out_grant, SECOND_TIE_WINNER);
    next_cycle(); in_i_read_en = 1'b0; in_d_read_en = 1'b0;
    next_cycle(); #1;
    check("b6_grant", out_grant, 2'b00);
    $display("[TB] back-to-back ties");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
